// File: rtl/tt_sweep.sv
// Truth-table sweeper: steps a combinational block through every input row,
// samples its output after a settle window and scores it against a reference table.
module tt_sweep #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        mismatch_count,
    output logic                 match
);

    localparam int                ROWS        = 2**N_IN;
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0]   ROW_LAST    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ROWS-1:0]   r_expected;
    logic [ROWS-1:0]   r_table;
    logic [N_IN-1:0]   r_row;
    logic [3:0]        r_settle;
    logic [N_IN:0]     r_mism;
    logic              r_swept;
    logic              w_sample;
    logic              w_last;

    // Only the final cycle of each row's settle window is sampled.
    assign w_sample = (r_state == RUN) && (r_settle == 4'd0);
    assign w_last   = (r_row == ROW_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_sample && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_expected <= '0;
            r_table    <= '0;
            r_mism     <= '0;
            r_row      <= '0;
            r_settle   <= '0;
            r_swept    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_expected <= expected;
                        r_table    <= '0;
                        r_mism     <= '0;
                        r_row      <= '0;
                        r_settle   <= SETTLE_LAST;
                        r_swept    <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_sample) begin
                        r_table[r_row] <= dut_out;
                        if (dut_out != r_expected[r_row])
                            r_mism <= r_mism + (N_IN+1)'(1);
                        if (!w_last) begin
                            r_row    <= r_row + N_IN'(1);
                            r_settle <= SETTLE_LAST;
                        end
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                DONE:    r_swept <= 1'b1;
                default: ;
            endcase
        end
    end

    // Results stay qualified in IDLE after a completed sweep until the next start.
    assign dut_in         = (r_state == RUN) ? r_row : '0;
    assign busy           = (r_state == RUN);
    assign done           = (r_state == DONE);
    assign table_out      = r_table;
    assign mismatch_count = r_mism;
    assign match          = (done || ((r_state == IDLE) && r_swept)) && (r_mism == '0);

endmodule

// File: tb/tb_tt_sweep.sv
// Directed bench for tt_sweep: an XOR block on a 2-input/2-cycle sweeper and a
// constant-1 block on a 4-input/1-cycle sweeper.
module tb_tt_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [3:0]  exp_a;
    logic [15:0] exp_b;
    logic [1:0]  din_a;
    logic [3:0]  din_b;
    logic        dout_a;
    logic        busy_a, done_a, match_a;
    logic        busy_b, done_b, match_b;
    logic [3:0]  tab_a;
    logic [15:0] tab_b;
    logic [2:0]  mc_a;
    logic [4:0]  mc_b;
    logic        inj;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // XOR block, optionally corrupted while inj is high.
    assign dout_a = din_a[0] ^ din_a[1] ^ inj;

    tt_sweep #(.N_IN(2), .SETTLE(2)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(exp_a),
        .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
        .table_out(tab_a), .mismatch_count(mc_a), .match(match_a)
    );

    tt_sweep #(.N_IN(4), .SETTLE(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(exp_b),
        .dut_in(din_b), .dut_out(1'b1), .busy(busy_b), .done(done_b),
        .table_out(tab_b), .mismatch_count(mc_b), .match(match_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (cycle 0) and check cycles 1..10.
    task automatic sweep_a(input logic [3:0] e, input logic [3:0] want_tab,
                           input logic [2:0] want_mc, input logic want_match,
                           input bit do_inj);
        exp_a   = e;
        start_a = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            start_a = 1'b0;
            if (k == 2) exp_a = ~e;
            inj = do_inj && (k % 2 == 1) && (k <= 8);
            if (k <= 8) begin
                chk("dut_in_row", 32'(din_a), 32'((k - 1) / 2));
                chk("busy_run", 32'(busy_a), 1);
                chk("done_early", 32'(done_a), 0);
            end else begin
                chk("done_pulse", 32'(done_a), 1);
                chk("busy_done", 32'(busy_a), 0);
                chk("dut_in_done", 32'(din_a), 0);
                chk("table", 32'(tab_a), 32'(want_tab));
                chk("mismatch", 32'(mc_a), 32'(want_mc));
                chk("match_done", 32'(match_a), 32'(want_match));
            end
        end
        inj = 1'b0;
        tick();
        chk("done_single", 32'(done_a), 0);
        chk("table_hold", 32'(tab_a), 32'(want_tab));
        chk("mismatch_hold", 32'(mc_a), 32'(want_mc));
        chk("match_hold", 32'(match_a), 32'(want_match));
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        exp_a = '0; exp_b = '0; inj = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_din", 32'(din_a), 0);
        chk("rst_table", 32'(tab_a), 0);
        chk("rst_mism", 32'(mc_a), 0);
        chk("rst_match", 32'(match_a), 0);
        tick();

        // Correct reference, then a wrong one, then first-cycle corruption.
        sweep_a(4'b0110, 4'b0110, 3'd0, 1'b1, 1'b0);
        sweep_a(4'b1000, 4'b0110, 3'd3, 1'b0, 1'b0);
        sweep_a(4'b0110, 4'b0110, 3'd0, 1'b1, 1'b1);

        // Start pulses during RUN and DONE are ignored; a start in IDLE restarts.
        exp_a   = 4'b0110;
        start_a = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            start_a = (k == 3 || k == 9 || k == 10);
            if (k <= 8) begin
                chk("ign_busy", 32'(busy_a), 1);
                chk("ign_done", 32'(done_a), 0);
            end else if (k == 9) begin
                chk("ign_done9", 32'(done_a), 1);
                chk("ign_busy9", 32'(busy_a), 0);
            end else if (k == 10) begin
                chk("ign_idle10", 32'(busy_a), 0);
                chk("ign_done10", 32'(done_a), 0);
            end else if (k == 11) begin
                chk("restart_busy", 32'(busy_a), 1);
                chk("restart_din", 32'(din_a), 0);
            end else if (k < 19) begin
                chk("restart_nodone", 32'(done_a), 0);
            end else begin
                chk("restart_done", 32'(done_a), 1);
                chk("restart_match", 32'(match_a), 1);
            end
        end
        start_a = 1'b0;
        tick();

        // Reset in cycle 5 aborts the sweep with no done pulse.
        exp_a   = 4'b0110;
        start_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            start_a = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_din", 32'(din_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_table", 32'(tab_a), 0);
        chk("abort_mism", 32'(mc_a), 0);
        chk("abort_match", 32'(match_a), 0);
        for (int k = 0; k < 8; k++) begin
            chk("abort_nodone", 32'(done_a), 0);
            tick();
        end

        // Reset wins over a simultaneous start.
        rst     = 1'b1;
        start_a = 1'b1;
        tick();
        rst     = 1'b0;
        start_a = 1'b0;
        chk("rst_prio_busy", 32'(busy_a), 0);
        tick();
        chk("rst_prio_busy2", 32'(busy_a), 0);

        sweep_a(4'b0110, 4'b0110, 3'd0, 1'b1, 1'b0);

        // 16-row, single-cycle sweep with every row mismatching.
        exp_b   = 16'h0000;
        start_b = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            start_b = 1'b0;
            if (k <= 16) begin
                chk("b_din", 32'(din_b), 32'(k - 1));
                chk("b_nodone", 32'(done_b), 0);
            end else begin
                chk("b_done", 32'(done_b), 1);
                chk("b_table", 32'(tab_b), 32'hFFFF);
                chk("b_mism", 32'(mc_b), 16);
                chk("b_match", 32'(match_b), 0);
            end
        end
        tick();
        chk("b_done_single", 32'(done_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SHALL have parameter N_IN, default 2, number of logic-block inputs swept (legal 1..4).
REQ-002 SHALL have parameter SETTLE, default 2, cycles each input row is held before sampling (legal 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port start  input  1  sweep request; sampled in IDLE only.
REQ-006 SHALL have port expected  input  2**N_IN  reference truth table; bit i is the expected output for input row i; latched on accepted start.
REQ-007 SHALL have port dut_in  output  N_IN  input vector driven into the combinational logic block; bit 0 maps to in1, bit 1 to in2.
REQ-008 SHALL have port dut_out  input  1  logic block output being characterised.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start through the last RUN cycle.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port table_out  output  2**N_IN  measured truth table; bit i is the sampled dut_out for row i.
REQ-012 SHALL have port mismatch_count  output  N_IN+1  number of rows where measured differs from expected.
REQ-013 SHALL have port match  output  1  high when mismatch_count is zero, qualified by done or idle-after-sweep.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1, latch expected, clear table_out and mismatch_count, set row index to 0 and settle counter to SETTLE-1, and enter RUN.
REQ-016 SHALL drive dut_in = row index throughout RUN and dut_in = 0 in IDLE and DONE.
REQ-017 SHALL hold each row exactly SETTLE cycles; dut_out SHALL be sampled only on the last of those cycles; values on earlier cycles SHALL be ignored.
REQ-018 SHALL, on sampling, write dut_out to table_out[row] and increment mismatch_count if dut_out differs from the latched expected[row].
REQ-019 SHALL, after sampling row 2**N_IN-1, enter DONE; otherwise increment row and reload the settle counter to SETTLE-1.
REQ-020 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-021 SHALL produce done in cycle t+1+(2**N_IN)*SETTLE for a start accepted in cycle t.
REQ-022 SHALL hold table_out, mismatch_count and match stable from DONE until the next accepted start.
REQ-023 SHALL ignore start while in RUN or DONE; no restart, no extension of the sweep.
REQ-024 SHALL ignore changes on expected after the start is accepted.
REQ-025 SHALL size mismatch_count so 2**N_IN mismatches fit without wrap.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, enter IDLE and set dut_in=0, busy=0, done=0, table_out=0, mismatch_count=0, match=0.
REQ-027 SHALL abort any sweep in progress on reset, with no done pulse for the aborted sweep.
REQ-028 SHALL give rst priority over start in the same cycle.

Verification
REQ-029 N_IN=2, SETTLE=2, XOR model on dut_out, expected=4'b0110, start at cycle 0 -> dut_in 0,0,1,1,2,2,3,3 in cycles 1-8; done in cycle 9; table_out=0110; mismatch_count=0; match=1.
REQ-030 Same DUT, expected=4'b1000 -> done in cycle 9; table_out=0110; mismatch_count=3; match=0.
REQ-031 Start pulsed again in cycles 3 and 9 -> ignored; single done in cycle 9; busy falls after cycle 8; a start in cycle 10 begins a new sweep.
REQ-032 rst asserted in cycle 5 of a sweep -> cycle 6: dut_in=0, busy=0, all results 0; no done pulse until a new start completes.
REQ-033 dut_out forced to the wrong value on the first cycle of each row only -> table_out=0110; match=1, which proves the last-cycle-only sampling.
REQ-034 N_IN=4, SETTLE=1, dut_out tied 1, expected=16'h0000 -> done in cycle 17; table_out=16'hFFFF; mismatch_count=16; no wrap.
